frame_buffer_sequencer: RTL and testbench

Double-buffer sequencer for the 4-port SDRAM frame store, between the pixel source (camera/pattern writer) and the SDRAM controller's FIFO address/load inputs. It owns two SDRAM frame buffers, one being written and one being displayed. It gates writer pixels, counts each frame, and swaps buffers only on a VGA vertical-sync assertion after a complete frame. It emits the write/read base addresses and the FIFO LOAD pulses that re-arm the controller.

---
 rtl/frame_buffer_sequencer_if.sv | 41 ++++
 rtl/frame_buffer_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_frame_buffer_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : frame_buffer_sequencer_if
//  Purpose  : Bundles the pixel-source, VGA-sync and SDRAM FIFO control
//             signals of the frame buffer sequencer.
//  Modports : master - pixel source / display side (drives en, wr_valid,
//                      wr_sof, rd_vsync; observes all sequencer outputs)
//             slave  - the sequencer itself
//  Revision : 1.0  initial release
// ============================================================================
interface frame_buffer_sequencer_if;
  logic        en;          // swap enable; low freezes the displayed buffer
  logic        wr_valid;    // one source pixel per cycle when high
  logic        wr_sof;      // first pixel of a frame (qualified by wr_valid)
  logic        rd_vsync;    // VGA vertical sync, active-low level
  logic        wr_en;       // write strobe to both SDRAM write FIFOs
  logic [22:0] wr1_addr;    // write base, port 1 (red/green)
  logic [22:0] wr2_addr;    // write base, port 2 (blue)
  logic [22:0] rd1_addr;    // read base, port 1
  logic [22:0] rd2_addr;    // read base, port 2
  logic        wr_load;     // write FIFO address-load pulse
  logic        rd_load;     // read FIFO address-load pulse
  logic        wr_buf;      // buffer index being written
  logic        rd_buf;      // buffer index being displayed
  logic        frame_done;  // one-cycle pulse on frame completion
  logic [18:0] pix_cnt;     // pixels accepted in the current frame
  logic [7:0]  drop_cnt;    // dropped/aborted frames, saturating

  modport master (
    output en, wr_valid, wr_sof, rd_vsync,
    input  wr_en, wr1_addr, wr2_addr, rd1_addr, rd2_addr,
           wr_load, rd_load, wr_buf, rd_buf, frame_done, pix_cnt, drop_cnt
  );

  modport slave (
    input  en, wr_valid, wr_sof, rd_vsync,
    output wr_en, wr1_addr, wr2_addr, rd1_addr, rd2_addr,
           wr_load, rd_load, wr_buf, rd_buf, frame_done, pix_cnt, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/frame_buffer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : frame_buffer_sequencer
//  Purpose  : Double-buffer sequencer for the 4-port SDRAM frame store. Gates
//             source pixels into the write buffer, counts each frame, and
//             swaps write/display buffers on a VGA vsync fall once a complete
//             frame is waiting. Emits FIFO base addresses and LOAD pulses.
//  Ports    : clk  - system clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - frame_buffer_sequencer_if.slave (source strobes, vsync,
//                    swap enable in; write enable, addresses, loads, buffer
//                    indices, frame-done pulse and counters out)
//  Revision : 1.0  initial release
// ============================================================================
module frame_buffer_sequencer #(
  parameter int          FRAME_PIXELS = 307200,
  parameter logic [22:0] BUF_STRIDE   = 23'h080000,
  parameter logic [22:0] PORT2_OFFSET = 23'h100000,
  parameter int          LOAD_CYCLES  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  frame_buffer_sequencer_if.slave bus
);

  localparam logic [18:0] C_FP_LAST   = 19'(FRAME_PIXELS - 1);
  localparam int          C_LC_W      = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [C_LC_W-1:0] C_LOAD_LAST = C_LC_W'(LOAD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT_SOF = 3'd0,
    S_FILL     = 3'd1,
    S_PENDING  = 3'd2,
    S_SWAP     = 3'd3,
    S_WLOAD    = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [18:0]        r_count;
  logic [18:0]        w_count_nxt;
  logic [C_LC_W-1:0]  r_load_cnt;
  logic               r_vs_q;
  logic               r_wr_buf;
  logic               r_rd_buf;
  logic [22:0]        r_wr1_addr;
  logic [22:0]        r_wr2_addr;
  logic [22:0]        r_rd1_addr;
  logic [22:0]        r_rd2_addr;
  logic               r_wr_load;
  logic               r_rd_load;
  logic               r_frame_done;
  logic [7:0]         r_drop_cnt;

  logic               w_sof_pix;
  logic               w_vs_edge;
  logic               w_load_done;
  logic               w_drop;
  logic               w_complete;
  logic               w_swap;

  function automatic logic [22:0] f_base(input logic b);
    return b ? BUF_STRIDE : 23'd0;
  endfunction

  assign w_sof_pix   = bus.wr_valid & bus.wr_sof;
  // Falling edge of the active-low vsync level.
  assign w_vs_edge   = ~bus.rd_vsync & r_vs_q;
  assign w_load_done = (r_load_cnt == C_LOAD_LAST);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_drop      = 1'b0;
    w_complete  = 1'b0;
    w_swap      = 1'b0;

    case (r_state)
      S_WAIT_SOF: begin
        if (w_sof_pix) begin
          w_count_nxt = 19'd1;
          // A one-pixel frame is complete on its SOF pixel.
          if (FRAME_PIXELS == 1) begin
            w_state_nxt = S_PENDING;
            w_complete  = 1'b1;
          end else begin
            w_state_nxt = S_FILL;
          end
        end
      end

      S_FILL: begin
        if (w_sof_pix) begin
          // Count is always short of a full frame here, so any SOF aborts.
          w_drop      = 1'b1;
          w_count_nxt = 19'd0;
          w_state_nxt = S_WLOAD;
        end else if (bus.wr_valid) begin
          w_count_nxt = r_count + 19'd1;
          // A vsync fall in the same cycle is deliberately ignored: the
          // swap waits for the next fall.
          if (r_count == C_FP_LAST) begin
            w_state_nxt = S_PENDING;
            w_complete  = 1'b1;
          end
        end
      end

      S_PENDING: begin
        if (w_sof_pix) begin
          w_drop = 1'b1;
        end
        if (w_vs_edge && bus.en) begin
          w_swap      = 1'b1;
          w_count_nxt = 19'd0;
          w_state_nxt = S_SWAP;
        end
      end

      S_SWAP, S_WLOAD: begin
        if (w_load_done) begin
          w_state_nxt = S_WAIT_SOF;
        end
      end

      default: begin
        w_state_nxt = S_WAIT_SOF;
        w_count_nxt = 19'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_WAIT_SOF;
      r_count      <= 19'd0;
      r_load_cnt   <= '0;
      r_vs_q       <= 1'b1;
      r_wr_buf     <= 1'b0;
      r_rd_buf     <= 1'b1;
      r_wr1_addr   <= f_base(1'b0);
      r_wr2_addr   <= f_base(1'b0) + PORT2_OFFSET;
      r_rd1_addr   <= f_base(1'b1);
      r_rd2_addr   <= f_base(1'b1) + PORT2_OFFSET;
      // Loads stay asserted through reset so the controller FIFOs re-arm
      // on the reset addresses.
      r_wr_load    <= 1'b1;
      r_rd_load    <= 1'b1;
      r_frame_done <= 1'b0;
      r_drop_cnt   <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_vs_q       <= bus.rd_vsync;
      r_frame_done <= w_complete;

      // Load pulse length counter; zero on entry to either load state.
      if ((r_state == S_SWAP) || (r_state == S_WLOAD)) begin
        r_load_cnt <= r_load_cnt + C_LC_W'(1);
      end else begin
        r_load_cnt <= '0;
      end

      r_wr_load <= (w_state_nxt == S_SWAP) || (w_state_nxt == S_WLOAD);
      r_rd_load <= (w_state_nxt == S_SWAP);

      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end

      // The just-filled buffer becomes the display buffer.
      if (w_swap) begin
        r_wr_buf   <= ~r_wr_buf;
        r_rd_buf   <= r_wr_buf;
        r_wr1_addr <= f_base(~r_wr_buf);
        r_wr2_addr <= f_base(~r_wr_buf) + PORT2_OFFSET;
        r_rd1_addr <= f_base(r_wr_buf);
        r_rd2_addr <= f_base(r_wr_buf) + PORT2_OFFSET;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Combinational so the accepted pixel is written in the cycle it arrives;
  // an aborting SOF pixel is never written.
  assign bus.wr_en = bus.wr_valid &
                     (((r_state == S_FILL) & ~bus.wr_sof) |
                      ((r_state == S_WAIT_SOF) & bus.wr_sof));

  assign bus.wr1_addr   = r_wr1_addr;
  assign bus.wr2_addr   = r_wr2_addr;
  assign bus.rd1_addr   = r_rd1_addr;
  assign bus.rd2_addr   = r_rd2_addr;
  assign bus.wr_load    = r_wr_load;
  assign bus.rd_load    = r_rd_load;
  assign bus.wr_buf     = r_wr_buf;
  assign bus.rd_buf     = r_rd_buf;
  assign bus.frame_done = r_frame_done;
  assign bus.pix_cnt    = r_count;
  assign bus.drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_buffer_sequencer
//  Purpose  : Self-checking bench for frame_buffer_sequencer (16-pixel frames,
//             4-cycle loads). Expected values are queued as stimulus is
//             driven and compared once the corresponding cycle completes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frame_buffer_sequencer;
  localparam int          FP     = 16;
  localparam int          LC     = 4;
  localparam logic [22:0] STRIDE = 23'h080000;
  localparam logic [22:0] P2     = 23'h100000;

  localparam int SEL_WR_EN = 0, SEL_WR1 = 1, SEL_WR2 = 2, SEL_RD1 = 3,
                 SEL_RD2 = 4, SEL_WLD = 5, SEL_RLD = 6, SEL_WBUF = 7,
                 SEL_RBUF = 8, SEL_DONE = 9, SEL_PIX = 10, SEL_DROP = 11;

  typedef struct {
    int          sel;
    logic [22:0] val;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frame_buffer_sequencer_if bus ();

  frame_buffer_sequencer #(
    .FRAME_PIXELS(FP),
    .BUF_STRIDE  (STRIDE),
    .PORT2_OFFSET(P2),
    .LOAD_CYCLES (LC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t q_comb[$];
  exp_t q_reg[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic e_wr_buf;
  int   e_drop;

  function automatic logic [22:0] base(input logic b);
    return b ? STRIDE : 23'd0;
  endfunction

  function automatic logic [22:0] sample(input int sel);
    case (sel)
      SEL_WR_EN: return {22'd0, bus.wr_en};
      SEL_WR1:   return bus.wr1_addr;
      SEL_WR2:   return bus.wr2_addr;
      SEL_RD1:   return bus.rd1_addr;
      SEL_RD2:   return bus.rd2_addr;
      SEL_WLD:   return {22'd0, bus.wr_load};
      SEL_RLD:   return {22'd0, bus.rd_load};
      SEL_WBUF:  return {22'd0, bus.wr_buf};
      SEL_RBUF:  return {22'd0, bus.rd_buf};
      SEL_DONE:  return {22'd0, bus.frame_done};
      SEL_PIX:   return {4'd0, bus.pix_cnt};
      SEL_DROP:  return {15'd0, bus.drop_cnt};
      default:   return 23'h7fffff;
    endcase
  endfunction

  task automatic check(input string tag, input logic [22:0] got, input logic [22:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic exp_c(input int sel, input logic [22:0] v, input string tag);
    exp_t e;
    e.sel = sel; e.val = v; e.tag = tag;
    q_comb.push_back(e);
  endtask

  task automatic exp_r(input int sel, input logic [22:0] v, input string tag);
    exp_t e;
    e.sel = sel; e.val = v; e.tag = tag;
    q_reg.push_back(e);
  endtask

  // Combinational expectations are checked before the edge, registered ones
  // 1 time unit after it.
  task automatic tick();
    exp_t e;
    #2;
    while (q_comb.size() > 0) begin
      e = q_comb.pop_front();
      check(e.tag, sample(e.sel), e.val);
    end
    @(posedge clk);
    #1;
    while (q_reg.size() > 0) begin
      e = q_reg.pop_front();
      check(e.tag, sample(e.sel), e.val);
    end
  endtask

  task automatic exp_bufs(input logic wb, input logic rb);
    exp_r(SEL_WBUF, {22'd0, wb}, "wr_buf");
    exp_r(SEL_RBUF, {22'd0, rb}, "rd_buf");
    exp_r(SEL_WR1, base(wb), "wr1_addr");
    exp_r(SEL_WR2, base(wb) + P2, "wr2_addr");
    exp_r(SEL_RD1, base(rb), "rd1_addr");
    exp_r(SEL_RD2, base(rb) + P2, "rd2_addr");
  endtask

  task automatic exp_loads(input logic w, input logic r);
    exp_r(SEL_WLD, {22'd0, w}, "wr_load");
    exp_r(SEL_RLD, {22'd0, r}, "rd_load");
  endtask

  // Full frame from WAIT_SOF; optional idle gap and vsync fall on last pixel.
  task automatic do_frame(input bit vs_on_last, input bit gap);
    for (int i = 0; i < FP; i++) begin
      if (gap && i == 6) begin
        bus.wr_valid = 1'b0; bus.wr_sof = 1'b0;
        exp_c(SEL_WR_EN, 23'd0, "wr_en_gap");
        exp_r(SEL_PIX, 23'(i), "pix_gap");
        tick();
      end
      bus.wr_valid = 1'b1;
      bus.wr_sof   = (i == 0);
      if (vs_on_last && i == FP - 1) bus.rd_vsync = 1'b0;
      exp_c(SEL_WR_EN, 23'd1, "wr_en_pix");
      exp_r(SEL_PIX, 23'(i + 1), "pix_cnt");
      if (i == FP - 1) begin
        exp_r(SEL_DONE, 23'd1, "frame_done");
        exp_r(SEL_WLD, 23'd0, "no_swap_load");
        exp_r(SEL_WBUF, {22'd0, e_wr_buf}, "wr_buf_hold");
      end else begin
        exp_r(SEL_DONE, 23'd0, "done_low");
      end
      tick();
    end
    bus.wr_valid = 1'b0; bus.wr_sof = 1'b0;
    exp_r(SEL_DONE, 23'd0, "done_pulse_end");
    exp_r(SEL_PIX, 23'(FP), "pix_full");
    exp_r(SEL_WLD, 23'd0, "pend_load");
    tick();
  endtask

  // Vsync fall from PENDING with en high; full runs all load cycles.
  task automatic do_swap(input bit full, input bit sof_with_vs);
    logic nb;
    nb = ~e_wr_buf;
    bus.rd_vsync = 1'b0;
    if (sof_with_vs) begin
      bus.wr_valid = 1'b1; bus.wr_sof = 1'b1;
      e_drop++;
      exp_c(SEL_WR_EN, 23'd0, "wr_en_swap_sof");
      exp_r(SEL_DROP, 23'(e_drop), "drop_swap_sof");
    end
    exp_loads(1'b1, 1'b1);
    exp_bufs(nb, e_wr_buf);
    exp_r(SEL_PIX, 23'd0, "pix_swap");
    tick();
    bus.wr_valid = 1'b0; bus.wr_sof = 1'b0;
    e_wr_buf = nb;
    for (int k = 1; k < (full ? LC : 2); k++) begin
      if (k == 1) begin
        bus.wr_valid = 1'b1; bus.wr_sof = 1'b1;
        exp_c(SEL_WR_EN, 23'd0, "wr_en_in_swap");
      end
      exp_loads(1'b1, 1'b1);
      exp_r(SEL_DROP, 23'(e_drop), "drop_in_swap");
      tick();
      bus.wr_valid = 1'b0; bus.wr_sof = 1'b0;
    end
    if (full) begin
      exp_loads(1'b0, 1'b0);
      exp_bufs(e_wr_buf, ~e_wr_buf);
      tick();
      bus.rd_vsync = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b1; bus.wr_valid = 1'b0; bus.wr_sof = 1'b0; bus.rd_vsync = 1'b1;
    e_wr_buf = 1'b0;
    e_drop   = 0;

    // Reset release
    for (int i = 0; i < 3; i++) begin
      exp_loads(1'b1, 1'b1);
      if (i == 2) begin
        exp_bufs(1'b0, 1'b1);
        exp_r(SEL_DROP, 23'd0, "drop_rst");
        exp_r(SEL_PIX, 23'd0, "pix_rst");
        exp_r(SEL_DONE, 23'd0, "done_rst");
      end
      tick();
    end
    rst = 1'b0;
    exp_loads(1'b0, 1'b0);
    tick();

    // Non-SOF pixels are ignored while waiting
    bus.wr_valid = 1'b1;
    exp_c(SEL_WR_EN, 23'd0, "wr_en_no_sof");
    exp_r(SEL_PIX, 23'd0, "pix_no_sof");
    tick();
    bus.wr_valid = 1'b0;

    // Full frame and swap
    do_frame(1'b0, 1'b1);
    do_swap(1'b1, 1'b0);

    // Early SOF after 10 pixels
    for (int i = 0; i < 10; i++) begin
      bus.wr_valid = 1'b1; bus.wr_sof = (i == 0);
      exp_c(SEL_WR_EN, 23'd1, "wr_en_early");
      exp_r(SEL_PIX, 23'(i + 1), "pix_early");
      tick();
    end
    bus.wr_sof = 1'b1;
    e_drop++;
    exp_c(SEL_WR_EN, 23'd0, "wr_en_abort");
    exp_r(SEL_DROP, 23'(e_drop), "drop_early");
    exp_r(SEL_PIX, 23'd0, "pix_abort");
    exp_loads(1'b1, 1'b0);
    exp_bufs(e_wr_buf, ~e_wr_buf);
    tick();
    bus.wr_valid = 1'b0; bus.wr_sof = 1'b0;
    for (int k = 1; k < LC; k++) begin
      exp_loads(1'b1, 1'b0);
      tick();
    end
    exp_loads(1'b0, 1'b0);
    tick();

    // Display hold
    bus.en = 1'b0;
    do_frame(1'b0, 1'b0);
    for (int v = 0; v < 3; v++) begin
      bus.rd_vsync = 1'b0;
      exp_r(SEL_WLD, 23'd0, "hold_load");
      exp_r(SEL_WBUF, {22'd0, e_wr_buf}, "hold_wr_buf");
      exp_r(SEL_PIX, 23'(FP), "hold_pix");
      tick();
      bus.rd_vsync = 1'b1;
      tick();
    end
    for (int s = 0; s < 2; s++) begin
      bus.wr_valid = 1'b1; bus.wr_sof = 1'b1;
      e_drop++;
      exp_c(SEL_WR_EN, 23'd0, "wr_en_pend");
      exp_r(SEL_DROP, 23'(e_drop), "drop_pend");
      tick();
      bus.wr_valid = 1'b0; bus.wr_sof = 1'b0;
    end
    bus.en = 1'b1;
    do_swap(1'b1, 1'b1);

    // Collision: completing pixel with vsync fall
    do_frame(1'b1, 1'b0);
    bus.rd_vsync = 1'b1;
    exp_r(SEL_WLD, 23'd0, "coll_load");
    tick();
    do_swap(1'b1, 1'b0);

    // Saturation then reset mid-SWAP
    do_frame(1'b0, 1'b0);
    for (int s = 0; s < 300; s++) begin
      bus.wr_valid = 1'b1; bus.wr_sof = 1'b1;
      if (e_drop < 255) e_drop++;
      exp_r(SEL_DROP, 23'(e_drop), "drop_sat");
      tick();
    end
    bus.wr_valid = 1'b0; bus.wr_sof = 1'b0;
    do_swap(1'b0, 1'b0);
    rst = 1'b1;
    exp_bufs(1'b0, 1'b1);
    exp_loads(1'b1, 1'b1);
    exp_r(SEL_DROP, 23'd0, "drop_rst2");
    exp_r(SEL_PIX, 23'd0, "pix_rst2");
    exp_r(SEL_DONE, 23'd0, "done_rst2");
    tick();
    e_wr_buf = 1'b0;
    e_drop   = 0;
    rst = 1'b0;
    bus.rd_vsync = 1'b1;
    exp_loads(1'b0, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
